// File: rtl/flintstone_mem_pkg.sv
// Shared definitions for the flintstone dual-port SRAM access path:
// geometry defaults, arbiter FSM encoding and requester ids.
package flintstone_mem_pkg;

  localparam int ADDR_W_DEF = 15;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DATA  = 2'd2
  } arb_state_e;

  localparam logic REQ_ID0 = 1'b0;
  localparam logic REQ_ID1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin pick: a lone requester always wins,
// a tie goes to the requester named by prio.
module rr_arb2
  import flintstone_mem_pkg::*;
(
  input  logic [1:0] req,
  input  logic       prio,
  output logic       winner,
  output logic       valid
);

  // winner selection
  always_comb begin
    winner = REQ_ID0;
    valid  = req[0] | req[1];
    case (req)
      2'b01:   winner = REQ_ID0;
      2'b10:   winner = REQ_ID1;
      2'b11:   winner = prio;
      default: winner = REQ_ID0;
    endcase
  end

endmodule

// File: rtl/sram_arbiter.sv
// Port-A access controller for the 32K x 16 dual-port SRAM: serialises two
// requesters through an IDLE/ISSUE/DATA sequence with registered handshakes.
module sram_arbiter
  import flintstone_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req0,
  input  logic              i_req1,
  input  logic              i_we0,
  input  logic              i_we1,
  input  logic [ADDR_W-1:0] i_addr0,
  input  logic [ADDR_W-1:0] i_addr1,
  input  logic [DATA_W-1:0] i_wdata0,
  input  logic [DATA_W-1:0] i_wdata1,
  output logic              o_gnt0,
  output logic              o_gnt1,
  output logic              o_ack0,
  output logic              o_ack1,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_sram_we,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic [DATA_W-1:0] o_sram_wdata,
  input  logic [DATA_W-1:0] i_sram_rdata
);

  arb_state_e        state_r;
  arb_state_e        state_next_s;
  logic              prio_r;
  logic              id_r;
  logic              win_id_s;
  logic              win_valid_s;
  logic              launch_s;
  logic              finish_s;
  logic              sel_we_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [DATA_W-1:0] sel_wdata_s;

  rr_arb2 u_rr_arb2 (
    .req    ({i_req1, i_req0}),
    .prio   (prio_r),
    .winner (win_id_s),
    .valid  (win_valid_s)
  );

  // FSM state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (win_valid_s) begin
          state_next_s = ISSUE;
        end else begin
          state_next_s = IDLE;
        end
      end
      ISSUE:   state_next_s = DATA;
      DATA:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // FSM output decode and winner field mux
  always_comb begin
    launch_s    = 1'b0;
    finish_s    = 1'b0;
    sel_we_s    = i_we0;
    sel_addr_s  = i_addr0;
    sel_wdata_s = i_wdata0;
    case (state_r)
      IDLE:    launch_s = win_valid_s;
      DATA:    finish_s = 1'b1;
      default: launch_s = 1'b0;
    endcase
    if (win_id_s == REQ_ID1) begin
      sel_we_s    = i_we1;
      sel_addr_s  = i_addr1;
      sel_wdata_s = i_wdata1;
    end else begin
      sel_we_s    = i_we0;
      sel_addr_s  = i_addr0;
      sel_wdata_s = i_wdata0;
    end
  end

  // Registered grant/ack pulses and SRAM write strobe; we is high only in ISSUE
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_gnt0    <= 1'b0;
      o_gnt1    <= 1'b0;
      o_ack0    <= 1'b0;
      o_ack1    <= 1'b0;
      o_sram_we <= 1'b0;
    end else begin
      o_gnt0    <= launch_s & (win_id_s == REQ_ID0);
      o_gnt1    <= launch_s & (win_id_s == REQ_ID1);
      o_ack0    <= finish_s & (id_r == REQ_ID0);
      o_ack1    <= finish_s & (id_r == REQ_ID1);
      o_sram_we <= launch_s & sel_we_s;
    end
  end

  // Request latch, priority pointer and read-data capture
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      prio_r       <= REQ_ID0;
      id_r         <= REQ_ID0;
      o_sram_addr  <= {ADDR_W{1'b0}};
      o_sram_wdata <= {DATA_W{1'b0}};
      o_rdata      <= {DATA_W{1'b0}};
    end else begin
      if (launch_s) begin
        id_r         <= win_id_s;
        prio_r       <= ~win_id_s;
        o_sram_addr  <= sel_addr_s;
        o_sram_wdata <= sel_wdata_s;
      end
      if (finish_s) begin
        o_rdata <= i_sram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter with a behavioural 32K x 16 SRAM port
// whose read data follows a registered address.
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [14:0] addr0 = 15'h0, addr1 = 15'h0;
  logic [15:0] wd0 = 16'h0, wd1 = 16'h0;
  logic        gnt0, gnt1, ack0, ack1, sram_we;
  logic [15:0] rdata, sram_wdata, sram_rdata;
  logic [14:0] sram_addr;

  logic [15:0] mem [0:32767];
  logic [14:0] mem_addr_q = 15'h0;
  logic        pl_we = 1'b0;
  logic [14:0] pl_addr = 15'h0;
  logic [15:0] pl_data = 16'h0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // SRAM port A model plus a bench-side preload path
  always @(posedge clk) begin
    if (pl_we) mem[pl_addr] <= pl_data;
    else if (sram_we) mem[sram_addr] <= sram_wdata;
    mem_addr_q <= sram_addr;
  end
  assign sram_rdata = mem[mem_addr_q];

  sram_arbiter dut (
    .i_clk(clk), .i_rst(rst),
    .i_req0(req0), .i_req1(req1), .i_we0(we0), .i_we1(we1),
    .i_addr0(addr0), .i_addr1(addr1), .i_wdata0(wd0), .i_wdata1(wd1),
    .o_gnt0(gnt0), .o_gnt1(gnt1), .o_ack0(ack0), .o_ack1(ack1),
    .o_rdata(rdata), .o_sram_we(sram_we), .o_sram_addr(sram_addr),
    .o_sram_wdata(sram_wdata), .i_sram_rdata(sram_rdata)
  );

  typedef struct {
    logic        r0, r1, w0, w1;
    logic [14:0] a0, a1;
    logic [15:0] d0, d1;
    logic        win;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [14:0] a, input logic [15:0] d);
    pl_we = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  // One access from IDLE: drive at a negedge, check T+1 (ISSUE), T+2 (DATA), T+3 (ack)
  task automatic run_row(input vec_t v, input int idx);
    logic        exp_we;
    logic [14:0] exp_a;
    logic [15:0] exp_d;
    exp_we = v.win ? v.w1 : v.w0;
    exp_a  = v.win ? v.a1 : v.a0;
    exp_d  = v.win ? v.d1 : v.d0;
    req0 = v.r0; req1 = v.r1; we0 = v.w0; we1 = v.w1;
    addr0 = v.a0; addr1 = v.a1; wd0 = v.d0; wd1 = v.d1;
    @(negedge clk);
    chk($sformatf("row%0d_gnt0", idx), {31'd0, gnt0}, {31'd0, ~v.win});
    chk($sformatf("row%0d_gnt1", idx), {31'd0, gnt1}, {31'd0, v.win});
    chk($sformatf("row%0d_issue_we", idx), {31'd0, sram_we}, {31'd0, exp_we});
    chk($sformatf("row%0d_issue_addr", idx), {17'd0, sram_addr}, {17'd0, exp_a});
    chk($sformatf("row%0d_issue_wdata", idx), {16'd0, sram_wdata}, {16'd0, exp_d});
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    chk($sformatf("row%0d_data_we", idx), {31'd0, sram_we}, 32'd0);
    chk($sformatf("row%0d_data_gnt", idx), {30'd0, gnt1, gnt0}, 32'd0);
    @(negedge clk);
    chk($sformatf("row%0d_ack0", idx), {31'd0, ack0}, {31'd0, ~v.win});
    chk($sformatf("row%0d_ack1", idx), {31'd0, ack1}, {31'd0, v.win});
    chk($sformatf("row%0d_rdata", idx), {16'd0, rdata}, {16'd0, v.exp_rdata});
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 15'h0123, 15'h0000, 16'h0000, 16'h0000, 1'b0, 16'hBEEF};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 15'h0000, 15'h7FFF, 16'h0000, 16'h5A5A, 1'b1, 16'h5A5A};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 15'h7FFF, 15'h0000, 16'h0000, 16'h0000, 1'b0, 16'h5A5A};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 15'h0123, 15'h0010, 16'h0000, 16'h0000, 1'b1, 16'h1111};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 15'h0200, 15'h0300, 16'hA5A5, 16'h3C3C, 1'b0, 16'hA5A5};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 15'h0000, 15'h0200, 16'h0000, 16'h0000, 1'b1, 16'hA5A5};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 15'h0000, 15'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0000};
    vecs[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 15'h0000, 15'h0000, 16'h0000, 16'hFFFF, 1'b1, 16'hFFFF};

    // Reset with preload of the words the tests read back
    @(negedge clk);
    preload(15'h0123, 16'hBEEF);
    preload(15'h0010, 16'h1111);
    preload(15'h0000, 16'h0000);
    preload(15'h0500, 16'h0000);
    chk("rst_gnt", {30'd0, gnt1, gnt0}, 32'd0);
    chk("rst_ack", {30'd0, ack1, ack0}, 32'd0);
    chk("rst_rdata", {16'd0, rdata}, 32'd0);
    chk("rst_sram_we", {31'd0, sram_we}, 32'd0);
    chk("rst_sram_addr", {17'd0, sram_addr}, 32'd0);
    chk("rst_sram_wdata", {16'd0, sram_wdata}, 32'd0);
    rst = 1'b0;

    // Contention from reset: grants 0,1,0,1 three cycles apart
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
    addr0 = 15'h0123; addr1 = 15'h0010;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      chk($sformatf("cont_c%0d_gnt0", c), {31'd0, gnt0}, {31'd0, (c == 1 || c == 7)});
      chk($sformatf("cont_c%0d_gnt1", c), {31'd0, gnt1}, {31'd0, (c == 4 || c == 10)});
      chk($sformatf("cont_c%0d_ack0", c), {31'd0, ack0}, {31'd0, (c == 3 || c == 9)});
      chk($sformatf("cont_c%0d_ack1", c), {31'd0, ack1}, {31'd0, (c == 6 || c == 12)});
      if (c == 3 || c == 9) chk($sformatf("cont_c%0d_rdata", c), {16'd0, rdata}, 32'h0000BEEF);
      if (c == 6 || c == 12) chk($sformatf("cont_c%0d_rdata", c), {16'd0, rdata}, 32'h00001111);
      if (c == 10) begin
        req0 = 1'b0; req1 = 1'b0;
      end
    end

    // Table-driven accesses, chained so each starts in the previous ack cycle
    for (int i = 0; i < 8; i++) run_row(vecs[i], i);

    // Request withdrawn: req1 write pulsed only during another access's ISSUE
    req0 = 1'b1; we0 = 1'b0; addr0 = 15'h0123;
    @(negedge clk);
    chk("wd_gnt0", {31'd0, gnt0}, 32'd1);
    req0 = 1'b0; req1 = 1'b1; we1 = 1'b1; addr1 = 15'h0123; wd1 = 16'hDEAD;
    @(negedge clk);
    req1 = 1'b0;
    chk("wd_data_gnt1", {31'd0, gnt1}, 32'd0);
    chk("wd_data_we", {31'd0, sram_we}, 32'd0);
    for (int c = 3; c <= 6; c++) begin
      @(negedge clk);
      chk($sformatf("wd_c%0d_gnt1", c), {31'd0, gnt1}, 32'd0);
      chk($sformatf("wd_c%0d_we", c), {31'd0, sram_we}, 32'd0);
      if (c == 3) chk("wd_ack_rdata", {15'd0, ack0, rdata}, 32'h1BEEF);
    end
    chk("wd_mem_intact", {16'd0, mem[15'h0123]}, 32'h0000BEEF);

    // Field stability: requester fields change after the grant
    req0 = 1'b1; we0 = 1'b1; addr0 = 15'h0400; wd0 = 16'h1234;
    @(negedge clk);
    chk("fs_gnt0", {31'd0, gnt0}, 32'd1);
    chk("fs_issue_addr", {17'd0, sram_addr}, 32'h0400);
    chk("fs_issue_wdata", {16'd0, sram_wdata}, 32'h1234);
    req0 = 1'b0; addr0 = 15'h0500; wd0 = 16'h9999;
    @(negedge clk);
    chk("fs_data_addr", {17'd0, sram_addr}, 32'h0400);
    chk("fs_data_wdata", {16'd0, sram_wdata}, 32'h1234);
    @(negedge clk);
    chk("fs_ack_rdata", {15'd0, ack0, rdata}, 32'h11234);
    chk("fs_mem_0400", {16'd0, mem[15'h0400]}, 32'h1234);
    chk("fs_mem_0500", {16'd0, mem[15'h0500]}, 32'h0000);

    // Reset during the ISSUE cycle of a write: strobe drops at once, no write, no ack
    req1 = 1'b1; we1 = 1'b1; addr1 = 15'h0010; wd1 = 16'h2222;
    @(negedge clk);
    chk("ri_gnt1", {31'd0, gnt1}, 32'd1);
    chk("ri_issue_we", {31'd0, sram_we}, 32'd1);
    req1 = 1'b0;
    rst = 1'b1;
    #1;
    chk("ri_we_async", {31'd0, sram_we}, 32'd0);
    chk("ri_gnt_async", {31'd0, gnt1}, 32'd0);
    chk("ri_addr_async", {17'd0, sram_addr}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("ri_noack_c%0d", c), {30'd0, ack1, ack0}, 32'd0);
    end
    chk("ri_mem_old", {16'd0, mem[15'h0010]}, 32'h1111);
    run_row('{1'b1, 1'b0, 1'b0, 1'b0, 15'h0010, 15'h0000, 16'h0000, 16'h0000, 1'b0, 16'h1111}, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
